// File: rtl/branch_pc_unit_if.sv
// Fetch/redirect bundle between the EX stage, the branch PC unit and fetch.
interface branch_pc_unit_if;
  logic        STALL;
  logic        BR_VALID;
  logic        SIG_B;
  logic [31:0] BR_PC;
  logic [15:0] RAW_VAL;
  logic        JUMP;
  logic [25:0] JUMP_TARGET;
  logic [31:0] PC;
  logic        PC_VALID;
  logic        FLUSH;
  logic [15:0] TAKEN_CNT;

  // Driver side: EX-stage decisions in, fetch request out.
  modport master (
    output STALL, BR_VALID, SIG_B, BR_PC, RAW_VAL, JUMP, JUMP_TARGET,
    input  PC, PC_VALID, FLUSH, TAKEN_CNT
  );

  // Unit side.
  modport slave (
    input  STALL, BR_VALID, SIG_B, BR_PC, RAW_VAL, JUMP, JUMP_TARGET,
    output PC, PC_VALID, FLUSH, TAKEN_CNT
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Fetch PC register with branch/jump redirect, fixed-length flush window
// and a saturating redirect counter.
module branch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic           CLK,
  input  logic           RST_N,
  branch_pc_unit_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;

  // Counter holds remaining flush cycles minus one, so load N-1.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  logic [31:0] br_pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        take_branch;
  logic        redirect;

  // Target arithmetic; both targets are relative to the EX instruction + 4.
  always_comb begin
    br_pc4      = bus.BR_PC + 32'd4;
    br_target   = br_pc4 + {{14{bus.RAW_VAL[15]}}, bus.RAW_VAL, 2'b00};
    j_target    = {br_pc4[31:28], bus.JUMP_TARGET, 2'b00};
    take_branch = bus.BR_VALID & bus.SIG_B;
    redirect    = take_branch | bus.JUMP;
  end

  // Next-state, next-PC and counter logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    flush_cnt_d = flush_cnt_q;
    taken_cnt_d = taken_cnt_q;
    unique case (state_q)
      BOOT: begin
        // Leave boot without advancing the PC.
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          // Branch wins over a simultaneous jump; one count per redirect.
          pc_d        = take_branch ? br_target : j_target;
          state_d     = REDIRECT;
          flush_cnt_d = FLUSH_LOAD;
          if (taken_cnt_q != 16'hFFFF) taken_cnt_d = taken_cnt_q + 16'd1;
        end else if (!bus.STALL) begin
          pc_d = pc_q + 32'd4;
        end
      end
      REDIRECT: begin
        // Events here come from wrong-path instructions and are ignored.
        if (!bus.STALL) pc_d = pc_q + 32'd4;
        if (flush_cnt_q == 3'd0) state_d = RUN;
        else                     flush_cnt_d = flush_cnt_q - 3'd1;
      end
      default: state_d = BOOT;
    endcase
  end

  // State register; reset returns to BOOT immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      flush_cnt_q <= 3'd0;
      taken_cnt_q <= 16'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all
      // registers update together from pre-edge values.
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_cnt_q <= flush_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign bus.PC        = pc_q;
  assign bus.PC_VALID  = (state_q != BOOT);
  assign bus.FLUSH     = (state_q == REDIRECT);
  assign bus.TAKEN_CNT = taken_cnt_q;

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-redirect unit that consumes the ALU's branch decision (`SIG_B`) for BEQ/BNE and J-type instructions. It owns the fetch PC register, computes taken-branch and jump targets, redirects fetch, and asserts `FLUSH` for a fixed number of cycles so the pipeline can kill wrong-path instructions. It sits between the EX stage (ALU outputs) and the instruction-fetch stage.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded by reset.
- `FLUSH_CYCLES`, default 2: number of cycles `FLUSH` stays high after a redirect, legal range 1–7.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `STALL` input 1: hold PC; fetch is frozen.
- `BR_VALID` input 1: EX stage holds a conditional branch this cycle.
- `SIG_B` input 1: ALU branch decision, meaningful only when `BR_VALID`=1.
- `BR_PC` input 32: address of the instruction in EX.
- `RAW_VAL` input 16: branch immediate, signed word offset.
- `JUMP` input 1: EX stage holds an unconditional jump.
- `JUMP_TARGET` input 26: jump field of the instruction.
- `PC` output 32: current fetch address.
- `PC_VALID` output 1: `PC` is a valid fetch request.
- `FLUSH` output 1: kill instructions younger than EX.
- `TAKEN_CNT` output 16: count of redirects, saturating.

## Operation
- States: BOOT, RUN, REDIRECT.
- BOOT: entered on reset. `PC`=`RESET_VECTOR`, `PC_VALID`=0, `FLUSH`=0. Moves unconditionally to RUN on the first edge after `RST_N` deasserts. `PC` is not incremented on that edge.
- RUN, no event: if `STALL`=0 then `PC`<=`PC`+4; otherwise hold.
- Branch target = `BR_PC`+4+({{14{`RAW_VAL`[15]}},`RAW_VAL`,2'b00}), modulo 2^32 (wrap, no error).
- Jump target = {(`BR_PC`+4)[31:28], `JUMP_TARGET`, 2'b00}.
- Redirect event in RUN: (`BR_VALID`&`SIG_B`) or `JUMP`. On the edge, `PC` loads the target, the state becomes REDIRECT, the flush counter loads `FLUSH_CYCLES`-1, and `TAKEN_CNT` increments, saturating at 16'hFFFF.
- A redirect overrides `STALL`: the target is loaded even when `STALL`=1.
- `BR_VALID`=1 with `SIG_B`=0 is treated as no event; fall-through applies.
- `BR_VALID`&`SIG_B` together with `JUMP` in the same cycle: the branch target wins and only one count is added.
- REDIRECT: `FLUSH`=1 and `PC_VALID`=1.
  - `BR_VALID` and `JUMP` are ignored because they come from wrong-path instructions.
  - `PC` advances by +4 unless `STALL`=1.
  - The counter decrements each cycle. When it is 0, the next edge returns to RUN.
- Reset asserted in any state, including mid-REDIRECT: immediate asynchronous return to BOOT with all outputs at reset values and `TAKEN_CNT`=0.

## Timing
- Reset values: `PC`=`RESET_VECTOR`, `PC_VALID`=0, `FLUSH`=0, `TAKEN_CNT`=0, state BOOT.
- `PC_VALID` is 1 from the first cycle after BOOT. It drops only on reset.
- Redirect latency is 1 cycle: the event is sampled at edge N and `PC`=target in cycle N+1.
- `FLUSH` is high exactly `FLUSH_CYCLES` consecutive cycles, starting cycle N+1. `STALL` does not extend or shorten it.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset/boot: hold `RST_N`=0, then release.
  - Cycle 1: `PC`=0, `PC_VALID`=0.
  - Next cycle: `PC`=0, `PC_VALID`=1.
  - Then 4, 8, C on free-running edges.
- BNE taken: `BR_PC`=0x40, `RAW_VAL`=3, `BR_VALID`=1, `SIG_B`=1 (RS=15, RT=12).
  - Next `PC`=0x50.
  - `FLUSH` high 2 cycles.
  - `TAKEN_CNT`=1.
- BNE not taken: same inputs with `SIG_B`=0 (RS=RT=15).
  - `PC` steps +4.
  - `FLUSH` stays 0.
  - `TAKEN_CNT` unchanged.
- Negative offset and wrap:
  - `BR_PC`=0x40, `RAW_VAL`=16'hFFFE gives `PC`=0x3C.
  - `BR_PC`=0xFFFF_FFFC, `RAW_VAL`=1 gives `PC`=0x0000_0004.
- Jump with stall and ignored events:
  - `JUMP`=1, `JUMP_TARGET`=26'h10, `BR_PC`=0x1000, `STALL`=1 gives `PC`=0x40.
  - During REDIRECT, apply a taken branch. It is ignored: no `PC` change beyond the hold, and the count is not incremented.
- Reset mid-flush: assert `RST_N`=0 while `FLUSH`=1.
  - `FLUSH`=0, `PC`=`RESET_VECTOR`, `TAKEN_CNT`=0 immediately, without waiting for a clock edge.
- Saturation: force 65536 redirects.
  - `TAKEN_CNT` holds at 16'hFFFF.
